axi_sts_alert_poller: RTL and testbench

- AXI4-Lite read-only manager that pairs with the alerting status register on the subordinate side.
- When that register raises `alert`, or software pulses `trigger`, the block sweeps every status word in order over AR/R.
- It assembles the words into a shadow vector and publishes it atomically, with a one-cycle valid pulse.
- It sits in PL fabric beside the status register and gives fabric logic a coherent snapshot without PS involvement.

---
 rtl/axi_sts_alert_poller.sv | 155 +++++++++++++++
 tb/tb_axi_sts_alert_poller.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sts_alert_poller.sv
// rtl/axi_sts_alert_poller.sv - AXI4-Lite read-only poller that snapshots a status register bank
//
// Sweeps STS_SIZE status words over AR/R when the subordinate raises alert or
// software pulses trigger, then publishes the assembled vector atomically.
//
// Ports:
//   aclk, aresetn       clock, asynchronous active-low reset
//   enable              gates new sweeps (a sweep in progress always completes)
//   alert               level from the status register: data changed since last read
//   trigger             single-cycle request for one forced sweep
//   sts_data_out        last complete snapshot
//   sts_valid           one-cycle pulse while a fresh snapshot is presented
//   resp_err            some RRESP of the last sweep was not OKAY
//   busy                sweep in progress (start through DONE)
//   m_axi_ar*, m_axi_r* AXI4-Lite read address / read data channels
module axi_sts_alert_poller #(
  parameter int                        STS_DATA_WIDTH = 1024,
  parameter int                        AXI_DATA_WIDTH = 32,
  parameter int                        AXI_ADDR_WIDTH = 16,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                        HOLDOFF_CYCLES = 4
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      enable,
  input  logic                      alert,
  input  logic                      trigger,
  output logic [STS_DATA_WIDTH-1:0] sts_data_out,
  output logic                      sts_valid,
  output logic                      resp_err,
  output logic                      busy,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]                m_axi_arprot,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  localparam int STS_SIZE = STS_DATA_WIDTH / AXI_DATA_WIDTH;
  localparam int ADDR_LSB = $clog2(AXI_DATA_WIDTH / 8);
  localparam int IDX_W    = (STS_SIZE > 1) ? $clog2(STS_SIZE) : 1;
  localparam int HOLD_W   = $clog2(HOLDOFF_CYCLES + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STS_SIZE - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  logic [2:0]                state;
  logic [IDX_W-1:0]          idx;
  logic [STS_DATA_WIDTH-1:0] shadow;
  logic [STS_DATA_WIDTH-1:0] shadow_next;
  logic                      err;
  logic                      err_next;
  logic                      pending;
  logic [HOLD_W-1:0]         hold_cnt;
  logic                      start;

  assign start = enable & (alert | trigger | pending);

  // Shadow with the current beat merged in; used both to update the shadow
  // and to publish the snapshot on the final beat.
  always_comb begin
    shadow_next = shadow;
    shadow_next[int'(idx) * AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = m_axi_rdata;
  end

  assign err_next = err | (m_axi_rresp != 2'b00);

  // All handshake outputs decode straight from state, so an asynchronous
  // reset drops them immediately.
  assign m_axi_arvalid = (state == S_AR);
  assign m_axi_rready  = (state == S_R);
  assign sts_valid     = (state == S_DONE);
  assign busy          = (state == S_AR) || (state == S_R) || (state == S_DONE);
  assign m_axi_arprot  = 3'b000;
  assign m_axi_araddr  = BASE_ADDR + (AXI_ADDR_WIDTH'(idx) << ADDR_LSB);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= S_IDLE;
      idx          <= '0;
      shadow       <= '0;
      err          <= 1'b0;
      pending      <= 1'b0;
      hold_cnt     <= '0;
      sts_data_out <= '0;
      resp_err     <= 1'b0;
    end else begin
      // A trigger that cannot start a sweep right now is remembered once.
      if (trigger && ((state != S_IDLE) || !enable)) begin
        pending <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            idx     <= '0;
            err     <= 1'b0;
            pending <= 1'b0;
            state   <= S_AR;
          end
        end

        S_AR: begin
          if (m_axi_arready) begin
            state <= S_R;
          end
        end

        S_R: begin
          if (m_axi_rvalid) begin
            shadow <= shadow_next;
            err    <= err_next;
            if (idx == LAST_IDX) begin
              // Publish on the final beat so the snapshot is already
              // current during the DONE cycle that carries sts_valid.
              sts_data_out <= shadow_next;
              resp_err     <= err_next;
              state        <= S_DONE;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= S_AR;
            end
          end
        end

        S_DONE: begin
          hold_cnt <= HOLD_W'(HOLDOFF_CYCLES);
          state    <= S_HOLD;
        end

        S_HOLD: begin
          // Stays HOLDOFF_CYCLES cycles (leaves as the counter reaches 0)
          // unless a queued trigger cuts the holdoff short.
          if (pending || (hold_cnt <= HOLD_W'(1))) begin
            hold_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sts_alert_poller.sv
// tb/tb_axi_sts_alert_poller.sv - directed self-checking bench for axi_sts_alert_poller
module tb_axi_sts_alert_poller;

  localparam int SW = 64;
  localparam int DW = 32;
  localparam int AW = 16;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          enable = 1'b0;
  logic          alert = 1'b0;
  logic          trigger = 1'b0;
  logic [SW-1:0] sts_data_out;
  logic          sts_valid;
  logic          resp_err;
  logic          busy;
  logic [AW-1:0] m_axi_araddr;
  logic [2:0]    m_axi_arprot;
  logic          m_axi_arvalid;
  logic          m_axi_arready = 1'b0;
  logic [DW-1:0] m_axi_rdata = '0;
  logic [1:0]    m_axi_rresp = 2'b00;
  logic          m_axi_rvalid = 1'b0;
  logic          m_axi_rready;

  axi_sts_alert_poller #(
    .STS_DATA_WIDTH(SW),
    .AXI_DATA_WIDTH(DW),
    .AXI_ADDR_WIDTH(AW),
    .BASE_ADDR     (16'h0040),
    .HOLDOFF_CYCLES(4)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .enable       (enable),
    .alert        (alert),
    .trigger      (trigger),
    .sts_data_out (sts_data_out),
    .sts_valid    (sts_valid),
    .resp_err     (resp_err),
    .busy         (busy),
    .m_axi_araddr (m_axi_araddr),
    .m_axi_arprot (m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata  (m_axi_rdata),
    .m_axi_rresp  (m_axi_rresp),
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready)
  );

  always #5 aclk = ~aclk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Subordinate model and monitors
  int            cyc = 0;
  logic [DW-1:0] mem [2];
  int            err_word = -1;
  logic [AW-1:0] stall_addr = 16'h0044;
  int            stall_left = 0;
  int            hold44 = 0;
  logic          have_req = 1'b0;
  logic [AW-1:0] lat_addr = '0;
  logic [AW-1:0] ar_q[$];
  int            valid_q[$];
  int            valid_cnt = 0;
  logic [SW-1:0] snap = '0;
  logic          snap_err = 1'b0;

  always @(posedge aclk) begin
    cyc++;
    if (aresetn) begin
      if (m_axi_rvalid && m_axi_rready) have_req = 1'b0;
      if (m_axi_arvalid && m_axi_arready) begin
        have_req = 1'b1;
        lat_addr = m_axi_araddr;
        ar_q.push_back(m_axi_araddr);
      end
    end
  end

  always @(negedge aclk) begin
    logic [AW-1:0] off;
    int            widx;
    if (!aresetn) begin
      m_axi_arready = 1'b0;
      m_axi_rvalid  = 1'b0;
    end else begin
      if (m_axi_arvalid) begin
        if (m_axi_araddr == 16'h0044) hold44++;
        if ((m_axi_araddr == stall_addr) && (stall_left > 0)) begin
          m_axi_arready = 1'b0;
          stall_left--;
        end else begin
          m_axi_arready = 1'b1;
        end
      end else begin
        m_axi_arready = 1'b0;
      end
      off  = lat_addr - 16'h0040;
      widx = int'(off >> 2);
      m_axi_rvalid = have_req;
      m_axi_rdata  = mem[widx % 2];
      m_axi_rresp  = (widx == err_word) ? 2'b10 : 2'b00;
      if (sts_valid) begin
        valid_cnt++;
        valid_q.push_back(cyc);
        snap     = sts_data_out;
        snap_err = resp_err;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge aclk);
      #1;
    end
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    tick(1);
    trigger = 1'b0;
  endtask

  task automatic wait_valid(input int n0, input string tag);
    int t = 0;
    while ((valid_cnt <= n0) && (t < 100)) begin
      tick(1);
      t++;
    end
    check(tag, 64'(valid_cnt > n0), 64'd1);
  endtask

  initial begin
    int s;
    int n0;
    int a0;
    int t;

    // Reset state
    tick(2);
    check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    check("rst_rready",  64'(m_axi_rready),  64'd0);
    check("rst_busy",    64'(busy),          64'd0);
    check("rst_valid",   64'(sts_valid),     64'd0);
    check("rst_data",    sts_data_out,       64'd0);
    check("rst_err",     64'(resp_err),      64'd0);
    check("rst_arprot",  64'(m_axi_arprot),  64'd0);
    aresetn = 1'b1;
    enable  = 1'b1;
    tick(2);

    // T1: alert-driven sweep, zero wait
    mem[0] = 32'h01234567;
    mem[1] = 32'h89ABCDEF;
    s = cyc; n0 = valid_cnt; a0 = ar_q.size();
    alert = 1'b1;
    tick(1);
    alert = 1'b0;
    wait_valid(n0, "t1_valid");
    check("t1_addr0", 64'(ar_q[a0]), 64'h0040);
    check("t1_addr1", 64'(ar_q[a0+1]), 64'h0044);
    check("t1_snap", snap, 64'h89ABCDEF_01234567);
    check("t1_latency", 64'(valid_q[n0] - s), 64'd5);
    check("t1_err", 64'(snap_err), 64'd0);
    check("t1_busy_done", 64'(busy), 64'd1);
    tick(1);
    check("t1_pulse_len", 64'(sts_valid), 64'd0);
    check("t1_busy_after", 64'(busy), 64'd0);
    tick(12);
    check("t1_once", 64'(valid_cnt - n0), 64'd1);
    check("t1_ar_cnt", 64'(ar_q.size() - a0), 64'd2);

    // T2: arready stalled 3 cycles on word 1
    mem[0] = 32'hDEADBEEF;
    mem[1] = 32'hCAFEF00D;
    stall_left = 3; hold44 = 0; n0 = valid_cnt;
    pulse_trigger();
    wait_valid(n0, "t2_valid");
    check("t2_hold44", 64'(hold44), 64'd4);
    check("t2_snap", snap, 64'hCAFEF00D_DEADBEEF);
    tick(12);
    check("t2_once", 64'(valid_cnt - n0), 64'd1);

    // T3: SLVERR on word 0, then a clean sweep
    err_word = 0; n0 = valid_cnt;
    pulse_trigger();
    wait_valid(n0, "t3_valid_err");
    check("t3_err_set", 64'(snap_err), 64'd1);
    tick(12);
    err_word = -1; n0 = valid_cnt;
    pulse_trigger();
    wait_valid(n0, "t3_valid_clean");
    check("t3_err_clr", 64'(snap_err), 64'd0);
    tick(12);

    // T4: three triggers during an alert-started sweep -> one extra sweep
    n0 = valid_cnt; a0 = ar_q.size();
    alert = 1'b1;
    tick(1);
    alert = 1'b0;
    repeat (3) begin
      pulse_trigger();
      tick(1);
    end
    tick(30);
    check("t4_ar_cnt", 64'(ar_q.size() - a0), 64'd4);
    check("t4_sweeps", 64'(valid_cnt - n0), 64'd2);
    check("t4_gap", 64'(valid_q[n0+1] - valid_q[n0]), 64'd7);

    // T5: alert ignored during holdoff, honoured after it
    n0 = valid_cnt;
    pulse_trigger();
    wait_valid(n0, "t5_valid");
    a0 = ar_q.size();
    alert = 1'b1;
    tick(3);
    alert = 1'b0;
    tick(15);
    check("t5_holdoff_no_ar", 64'(ar_q.size() - a0), 64'd0);
    n0 = valid_cnt;
    pulse_trigger();
    wait_valid(n0, "t5_valid2");
    n0 = valid_cnt; a0 = ar_q.size();
    alert = 1'b1;
    tick(8);
    alert = 1'b0;
    tick(20);
    check("t5_late_alert_ar", 64'(ar_q.size() - a0), 64'd2);
    check("t5_late_alert_sweep", 64'(valid_cnt - n0), 64'd1);

    // T6: asynchronous reset in R of word 1
    n0 = valid_cnt; a0 = ar_q.size();
    pulse_trigger();
    t = 0;
    while (!((ar_q.size() - a0 == 2) && m_axi_rready) && (t < 50)) begin
      tick(1);
      t++;
    end
    check("t6_reach_r1", 64'(t < 50), 64'd1);
    aresetn = 1'b0;
    have_req = 1'b0;
    #1;
    check("t6_arvalid", 64'(m_axi_arvalid), 64'd0);
    check("t6_rready", 64'(m_axi_rready), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_data", sts_data_out, 64'd0);
    tick(1);
    aresetn = 1'b1;
    tick(20);
    check("t6_no_valid", 64'(valid_cnt - n0), 64'd0);
    check("t6_data_after", sts_data_out, 64'd0);

    // T7: enable low blocks alert; trigger queues until enable returns
    a0 = ar_q.size();
    enable = 1'b0;
    alert  = 1'b1;
    tick(10);
    alert = 1'b0;
    tick(1);
    check("t7_disabled_alert", 64'(ar_q.size() - a0), 64'd0);
    n0 = valid_cnt;
    pulse_trigger();
    tick(5);
    check("t7_disabled_trig", 64'(ar_q.size() - a0), 64'd0);
    enable = 1'b1;
    wait_valid(n0, "t7_pending_valid");
    tick(12);
    check("t7_pending_ar", 64'(ar_q.size() - a0), 64'd2);
    check("t7_snap", snap, 64'hCAFEF00D_DEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
